fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipeline. Owns the PC, issues requests to instruction memory over a request/grant port and buffers returned instructions in a small in-order queue. Presents one instruction per cycle to ID, holds it while the hazard stall unit asserts `Stall`, and discards everything in flight on a branch/jump redirect from EX.

## Interface

Parameters:

- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `BUF_DEPTH`, default 3: instruction-queue entries. Minimum 2. Also the credit limit on outstanding requests plus queued entries.

Ports:

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `IMem_Req`  out  1  fetch request valid.
- `IMem_Addr`  out  32  fetch address (current PC register).
- `IMem_Gnt`  in  1  request accepted this cycle when `IMem_Req && IMem_Gnt`.
- `IMem_RValid`  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- `IMem_RData`  in  32  response instruction.
- `Stall`  in  1  hold the ID-facing instruction (load-use hazard).
- `Redirect`  in  1  control-flow redirect from EX.
- `Redirect_PC`  in  32  redirect target.
- `ID_Valid`  out  1  `ID_Instr`/`ID_PC` valid.
- `ID_Instr`  out  32  instruction at queue head; 32'h0000_0013 (NOP) when `!ID_Valid`.
- `ID_PC`  out  32  PC of `ID_Instr`; 0 when `!ID_Valid`.

## Operation

- **State:**
  - PC register.
  - Outstanding counter `out_cnt`, 0..BUF_DEPTH.
  - Drop counter `drop_cnt`, 0..BUF_DEPTH.
  - Issued-PC FIFO, BUF_DEPTH deep: PCs of granted requests.
  - Instruction queue, BUF_DEPTH deep: {PC, instr} entries with count `occ`.
- **Request:** `IMem_Req = !Redirect && (out_cnt + occ < BUF_DEPTH)`. Uses registered values only; no path from `Stall` to `IMem_Req`.
- **Grant:**
  - PC ← PC + 4, modulo 2^32; wraps from 32'hFFFF_FFFC to 0.
  - Push PC into the issued-PC FIFO.
  - `out_cnt` +1.
- **Response, with `drop_cnt == 0`:** pop the issued-PC FIFO, push {PC, `IMem_RData`} into the queue, `out_cnt` −1.
- **Response, with `drop_cnt > 0`:** pop the issued-PC FIFO, discard the data, `out_cnt` −1, `drop_cnt` −1.
- **Grant and response in the same cycle:** `out_cnt` unchanged.
- **Consume:** when `ID_Valid && !Stall`, pop the queue head. `Stall` with `!ID_Valid` has no effect.
- **Push and pop in the same cycle:** `occ` unchanged; a push into a full queue is impossible by the credit rule.
- **Redirect, highest priority:**
  - PC ← `Redirect_PC`.
  - Queue cleared: `occ` ← 0, head pointer reset.
  - `drop_cnt` ← `out_cnt` after this cycle's response, i.e. `out_cnt − IMem_RValid`. The same-cycle response is itself discarded, not queued.
  - `IMem_Req` forced 0, so no grant is possible that cycle.
  - `Stall` is ignored that cycle.
  - The issued-PC FIFO is not cleared; drained entries pop naturally as dropped responses arrive.
- **Redirect while `drop_cnt > 0`:** same rule; `drop_cnt` recomputed from `out_cnt`.
- **No misaligned-PC checks:** `Redirect_PC[1:0]` passes through unmodified.

## Timing

- **Reset values:**
  - PC = `RESET_PC`.
  - `out_cnt` = `drop_cnt` = `occ` = 0.
  - `IMem_Req` = 0 while `rst_n` is low.
  - `ID_Valid` = 0, `ID_Instr` = 32'h0000_0013, `ID_PC` = 0.
- **Startup:** first request with `IMem_Addr` = `RESET_PC` in the first cycle after `rst_n` rises.
- **Latency:** grant at cycle N, `IMem_RValid` at N+1 → `ID_Valid` at N+2 (registered queue, no bypass).
- **Throughput:** with 1-cycle memory, `BUF_DEPTH` = 3 and no stall, one instruction per cycle in steady state.
- **Redirect at cycle R:**
  - First request to `Redirect_PC` at R+1, provided credits allow.
  - `ID_Valid` = 0 from R+1 until the new instruction arrives.
- **Stall:** `ID_Instr`/`ID_PC`/`ID_Valid` stable for the full duration. The queue fills, then `IMem_Req` drops when `out_cnt + occ == BUF_DEPTH`.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). Memory responses arriving after reset release without a matching grant are ignored: with `out_cnt == 0`, `IMem_RValid` is a don't-care and causes no change.

## Test plan

- **Reset:** release reset with `RESET_PC` = 32'h0000_0100, grant always, 1-cycle responses → `IMem_Addr` sequence 0x100, 0x104, 0x108…; `ID_PC` 0x100 at cycle 2, then +4 every cycle; `ID_Valid` continuous.
- **Stall hold:** `Stall` held 5 cycles while `ID_PC` = 0x108 → `ID_PC`/`ID_Instr` constant; `IMem_Req` low once `out_cnt + occ` = 3; after release, 0x10C follows with no gap and no duplicate.
- **Redirect with 2 outstanding:** `Gnt` delayed responses, `Redirect` to 0x2000 with `out_cnt` = 2 → both stale responses dropped; next `ID_PC` is 0x2000; no stale PC ever reaches ID.
- **Redirect coinciding with `IMem_RValid`:** that response is discarded; `drop_cnt` = `out_cnt` − 1; `ID_Valid` = 0 next cycle; `IMem_Req` = 0 in the redirect cycle.
- **Backpressure:** `IMem_Gnt` random at 50%, responses after 1–4 cycles, random `Stall` → instruction stream matches a reference PC model in order, and `out_cnt + occ` ≤ 3 always.
- **PC wrap and reset:** redirect to 32'hFFFF_FFFC → next fetch address 0. Assert `rst_n` low mid-stream with 2 outstanding → outputs at reset values immediately; restart from `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues credit-limited
// requests to instruction memory, tags in-order responses with their PCs and
// queues them for ID. A redirect from EX clears the queue and arranges for
// every response still in flight to be discarded on arrival.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Gnt,
   input  logic        IMem_RValid,
   input  logic [31:0] IMem_RData,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   output logic        ID_Valid,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC
);

   localparam int              CW      = $clog2(BUF_DEPTH + 1);
   localparam int              PW      = $clog2(BUF_DEPTH);
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(BUF_DEPTH);
   localparam logic [PW-1:0]   LAST_P  = PW'(BUF_DEPTH - 1);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] iss_wr_q, iss_wr_d, iss_rd_q, iss_rd_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;

   // Storage arrays carry no reset: validity is tracked by the counters.
   logic [31:0]   iss_pc_q  [BUF_DEPTH];
   logic [31:0]   q_pc_q    [BUF_DEPTH];
   logic [31:0]   q_instr_q [BUF_DEPTH];

   logic grant, resp, keep, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   // Credit check uses registered counts only, so Stall never reaches the request.
   assign IMem_Req  = rst_n && !Redirect &&
                      (({1'b0, out_cnt_q} + {1'b0, occ_q}) < DEPTH_C);
   assign IMem_Addr = pc_q;

   assign grant = IMem_Req && IMem_Gnt;
   // A response with nothing outstanding (e.g. left over from before reset) is ignored.
   assign resp  = IMem_RValid && (out_cnt_q != '0);
   assign keep  = resp && (drop_cnt_q == '0) && !Redirect;
   assign ID_Valid = (occ_q != '0);
   assign pop   = ID_Valid && !Stall && !Redirect;

   assign ID_Instr = ID_Valid ? q_instr_q[head_q] : NOP;
   assign ID_PC    = ID_Valid ? q_pc_q[head_q]    : 32'h0;

   // Next-state for PC, credit counters and queue pointers; redirect dominates.
   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q + CW'(grant) - CW'(resp);
      iss_wr_d   = grant ? ptr_inc(iss_wr_q) : iss_wr_q;
      iss_rd_d   = resp  ? ptr_inc(iss_rd_q) : iss_rd_q;
      drop_cnt_d = drop_cnt_q;
      occ_d      = occ_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (Redirect) begin
         pc_d       = Redirect_PC;
         drop_cnt_d = out_cnt_q - CW'(resp);
         occ_d      = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (grant) pc_d = pc_q + 32'd4;
         if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
         occ_d  = occ_q + CW'(keep) - CW'(pop);
         head_d = pop  ? ptr_inc(head_q) : head_q;
         tail_d = keep ? ptr_inc(tail_q) : tail_q;
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         occ_q      <= '0;
         iss_wr_q   <= '0;
         iss_rd_q   <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         occ_q      <= occ_d;
         iss_wr_q   <= iss_wr_d;
         iss_rd_q   <= iss_rd_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Issued-PC FIFO and instruction queue payload writes.
   always_ff @(posedge clk) begin
      if (grant) iss_pc_q[iss_wr_q] <= pc_q;
      if (keep) begin
         q_pc_q[tail_q]    <= iss_pc_q[iss_rd_q];
         q_instr_q[tail_q] <= IMem_RData;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with an in-order memory
// model and a queue-based reference of the instruction stream seen by ID.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          DEPTH  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Gnt = 1'b0;
   logic        IMem_RValid = 1'b0;
   logic [31:0] IMem_RData = 32'h0;
   logic        Stall = 1'b0;
   logic        Redirect = 1'b0;
   logic [31:0] Redirect_PC = 32'h0;
   logic        ID_Valid;
   logic [31:0] ID_Instr;
   logic [31:0] ID_PC;

   fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Gnt(IMem_Gnt),
      .IMem_RValid(IMem_RValid), .IMem_RData(IMem_RData),
      .Stall(Stall), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
      .ID_Valid(ID_Valid), .ID_Instr(ID_Instr), .ID_PC(ID_PC)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct { logic [31:0] addr; int ready; } mreq_t;
   typedef struct { logic [31:0] pc; logic live; } mo_t;

   // Memory environment
   mreq_t mem_q[$];
   int    lat_min = 1, lat_max = 1;
   bit    spurious = 1'b0;
   bit    rv_real = 1'b0;

   // Reference model: PC, requests in flight, instructions waiting for ID
   logic [31:0] m_pc = RST_PC;
   mo_t         m_out[$];
   logic [31:0] m_buf[$];

   logic        exp_req, exp_vld;
   logic [31:0] exp_addr, exp_pc, exp_instr;
   logic        obs_req, obs_vld;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_clear();
      mem_q.delete();
      m_out.delete();
      m_buf.delete();
      m_pc = RST_PC;
      spurious = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      IMem_Gnt = 1'b0; IMem_RValid = 1'b0; Stall = 1'b0; Redirect = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
   endtask

   // Apply one cycle of inputs, predict outputs, sample the DUT at negedge.
   task automatic drive(input logic gnt, input logic stall, input logic redir,
                        input logic [31:0] rpc);
      IMem_Gnt = gnt; Stall = stall; Redirect = redir; Redirect_PC = rpc;
      rv_real = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
      if (rv_real) begin
         IMem_RValid = 1'b1; IMem_RData = instr_of(mem_q[0].addr);
      end else if (spurious) begin
         IMem_RValid = 1'b1; IMem_RData = 32'hDEAD_BEEF;
      end else begin
         IMem_RValid = 1'b0; IMem_RData = $urandom;
      end
      exp_req  = !redir && ((m_out.size() + m_buf.size()) < DEPTH);
      exp_addr = m_pc;
      exp_vld  = (m_buf.size() > 0);
      if (exp_vld) begin
         exp_pc = m_buf[0]; exp_instr = instr_of(m_buf[0]);
      end else begin
         exp_pc = 32'h0; exp_instr = NOP;
      end
      @(negedge clk);
      obs_req = IMem_Req; obs_addr = IMem_Addr;
      obs_vld = ID_Valid; obs_pc = ID_PC; obs_instr = ID_Instr;
   endtask

   // Advance model and memory across the rising edge.
   task automatic advance();
      mo_t   o;
      mreq_t mr;
      if (exp_vld && !Stall && !Redirect) void'(m_buf.pop_front());
      if (rv_real) begin
         o = m_out.pop_front();
         void'(mem_q.pop_front());
         if (o.live && !Redirect) m_buf.push_back(o.pc);
      end
      if (Redirect) begin
         m_buf.delete();
         for (int i = 0; i < m_out.size(); i++) begin
            mo_t t;
            t = m_out[i]; t.live = 1'b0; m_out[i] = t;
         end
         m_pc = Redirect_PC;
      end
      if (obs_req && IMem_Gnt) begin
         o.pc = m_pc; o.live = 1'b1;
         m_out.push_back(o);
         mr.addr  = obs_addr;
         mr.ready = cyc + $urandom_range(lat_max, lat_min);
         mem_q.push_back(mr);
         m_pc = m_pc + 32'd4;
      end
      spurious = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (IMem_Req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b want 0", IMem_Req);
         end
         checks++;
         if (ID_Valid !== 1'b0 || ID_Instr !== NOP || ID_PC !== 32'h0) begin
            errors++;
            $display("FAIL reset_id: got vld=%b instr=%h pc=%h want 0/%h/0",
                     ID_Valid, ID_Instr, ID_PC, NOP);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         checks++;
         if (obs_req !== 1'b1 || obs_addr !== RST_PC + 32'(4 * i)) begin
            errors++;
            $display("FAIL startup_addr c%0d: got req=%b addr=%h want 1/%h",
                     i, obs_req, obs_addr, RST_PC + 32'(4 * i));
         end
         checks++;
         if (i >= 2) begin
            if (obs_vld !== 1'b1 || obs_pc !== RST_PC + 32'(4 * (i - 2)) ||
                obs_instr !== instr_of(RST_PC + 32'(4 * (i - 2)))) begin
               errors++;
               $display("FAIL startup_id c%0d: got vld=%b pc=%h want 1/%h",
                        i, obs_vld, obs_pc, RST_PC + 32'(4 * (i - 2)));
            end
         end else if (obs_vld !== 1'b0) begin
            errors++; $display("FAIL startup_id c%0d: got vld=%b want 0", i, obs_vld);
         end
         advance();
      end
   endtask

   task automatic test_stall();
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (4) begin drive(1'b1, 1'b0, 1'b0, 32'h0); advance(); end
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h0);
         checks++;
         if (obs_vld !== 1'b1 || obs_pc !== 32'h108 || obs_instr !== instr_of(32'h108)) begin
            errors++;
            $display("FAIL stall_hold k%0d: got vld=%b pc=%h instr=%h want 1/108/%h",
                     k, obs_vld, obs_pc, obs_instr, instr_of(32'h108));
         end
         if (k >= 1) begin
            checks++;
            if (obs_req !== 1'b0) begin
               errors++; $display("FAIL stall_credit k%0d: got req=%b want 0", k, obs_req);
            end
         end
         advance();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         checks++;
         if (obs_vld !== 1'b1 || obs_pc !== 32'h108 + 32'(4 * k)) begin
            errors++;
            $display("FAIL stall_release k%0d: got vld=%b pc=%h want 1/%h",
                     k, obs_vld, obs_pc, 32'h108 + 32'(4 * k));
         end
         advance();
      end
   endtask

   task automatic test_redirect_outstanding();
      bit seen;
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (2) begin drive(1'b1, 1'b0, 1'b0, 32'h0); advance(); end
      drive(1'b1, 1'b0, 1'b1, 32'h2000);
      checks++;
      if (obs_req !== 1'b0) begin
         errors++; $display("FAIL redir2_req: got req=%b want 0", obs_req);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h2000) begin
         errors++;
         $display("FAIL redir2_fetch: got req=%b addr=%h want 1/00002000", obs_req, obs_addr);
      end
      advance();
      seen = 1'b0;
      for (int i = 0; i < 15 && !seen; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         if (obs_vld === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (obs_pc !== 32'h2000 || obs_instr !== instr_of(32'h2000)) begin
               errors++;
               $display("FAIL redir2_first: got pc=%h instr=%h want 00002000/%h",
                        obs_pc, obs_instr, instr_of(32'h2000));
            end
         end
         advance();
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL redir2_timeout: got no valid instr want pc 00002000");
      end
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (3) begin drive(1'b1, 1'b0, 1'b0, 32'h0); advance(); end
      drive(1'b1, 1'b0, 1'b1, 32'h3000);
      checks++;
      if (obs_req !== 1'b0 || IMem_RValid !== 1'b1) begin
         errors++;
         $display("FAIL redir_rv_req: got req=%b rvalid=%b want 0/1", obs_req, IMem_RValid);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_vld !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h3000) begin
         errors++;
         $display("FAIL redir_rv_next: got vld=%b req=%b addr=%h want 0/1/00003000",
                  obs_vld, obs_req, obs_addr);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_vld !== 1'b0) begin
         errors++; $display("FAIL redir_rv_gap: got vld=%b want 0", obs_vld);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_vld !== 1'b1 || obs_pc !== 32'h3000) begin
         errors++;
         $display("FAIL redir_rv_new: got vld=%b pc=%h want 1/00003000", obs_vld, obs_pc);
      end
      advance();
   endtask

   task automatic test_backpressure();
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         logic        g, s, r;
         logic [31:0] rp;
         g  = ($urandom_range(1, 0) == 1);
         s  = ($urandom_range(9, 0) < 3);
         r  = ($urandom_range(39, 0) == 0);
         rp = $urandom & 32'hFFFF_FFFC;
         drive(g, s, r, rp);
         checks++;
         if (obs_req !== exp_req || obs_addr !== exp_addr) begin
            errors++;
            $display("FAIL bp_req c%0d: got req=%b addr=%h want %b/%h",
                     cyc, obs_req, obs_addr, exp_req, exp_addr);
         end
         checks++;
         if (obs_vld !== exp_vld || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
            errors++;
            $display("FAIL bp_id c%0d: got vld=%b pc=%h instr=%h want %b/%h/%h",
                     cyc, obs_vld, obs_pc, obs_instr, exp_vld, exp_pc, exp_instr);
         end
         checks++;
         if (m_out.size() + m_buf.size() > DEPTH) begin
            errors++;
            $display("FAIL bp_credit c%0d: got %0d in flight+queued want <= %0d",
                     cyc, m_out.size() + m_buf.size(), DEPTH);
         end
         advance();
      end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      lat_min = 1; lat_max = 1;
      drive(1'b1, 1'b0, 1'b0, 32'h0); advance();
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checks++;
      if (obs_req !== 1'b0) begin
         errors++; $display("FAIL wrap_redir_req: got req=%b want 0", obs_req);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_addr0: got req=%b addr=%h want 1/fffffffc", obs_req, obs_addr);
      end
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_addr1: got req=%b addr=%h want 1/00000000", obs_req, obs_addr);
      end
      advance();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         checks++;
         if (obs_vld !== exp_vld || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
            errors++;
            $display("FAIL wrap_id c%0d: got vld=%b pc=%h want %b/%h",
                     cyc, obs_vld, obs_pc, exp_vld, exp_pc);
         end
         advance();
      end
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 10 && m_out.size() != 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0); advance();
      end
      checks++;
      if (m_out.size() != 2) begin
         errors++;
         $display("FAIL midreset_setup: got %0d outstanding want 2", m_out.size());
      end
      rst_n = 1'b0;
      IMem_RValid = 1'b0;
      #1;
      checks++;
      if (IMem_Req !== 1'b0 || IMem_Addr !== RST_PC || ID_Valid !== 1'b0 ||
          ID_Instr !== NOP || ID_PC !== 32'h0) begin
         errors++;
         $display("FAIL midreset_out: got req=%b addr=%h vld=%b instr=%h pc=%h want 0/%h/0/%h/0",
                  IMem_Req, IMem_Addr, ID_Valid, ID_Instr, ID_PC, RST_PC, NOP);
      end
      model_clear();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0; lat_min = 1; lat_max = 1;
      spurious = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0);
         checks++;
         if (obs_req !== exp_req || obs_addr !== exp_addr ||
             obs_vld !== exp_vld || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
            errors++;
            $display("FAIL restart c%0d: got req=%b addr=%h vld=%b pc=%h instr=%h want %b/%h/%b/%h/%h",
                     i, obs_req, obs_addr, obs_vld, obs_pc, obs_instr,
                     exp_req, exp_addr, exp_vld, exp_pc, exp_instr);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_outstanding();
      test_redirect_rvalid();
      test_backpressure();
      test_wrap_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
